dac_serial_tx: RTL and testbench
================================

Name: dac_serial_tx

Overview:
- Parametrised serial DAC frame transmitter; successor of the single-channel two-byte transmission controller.
- On each sample-rate tick it snapshots N_CH channel words and shifts each out MSB-first as an {address, data} frame.
- Drives the shift enable, chip select and serial data line, then issues a start-of-conversion pulse to the DAC.
- Sits between the waveform generator (data source, tick source) and the external DAC pins.

Parameters:
DATA_W, 16, bits per channel data word (>=2)
N_CH, 2, number of channels per frame (1..16)
CH_ADDR_W, 2, channel address bits prepended to each word (>=1, 2**CH_ADDR_W >= N_CH)
GAP_CYC, 1, cs_n-high cycles after every channel frame (>=1)
SOC_LEN, 1, soc pulse length in cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
tick  in  1  sample-rate strobe, one cycle
data_in  in  N_CH*DATA_W  channel words; channel k at bits [k*DATA_W +: DATA_W]
ch_en  in  N_CH  per-channel enable, sampled with data_in
si_en  out  1  shift enable, high while a bit is valid on sdo
sdo  out  1  serial data, MSB-first
cs_n  out  1  DAC chip select, active-low
soc  out  1  start of conversion
busy  out  1  frame in progress
done  out  1  one-cycle end-of-frame pulse
overrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- All outputs are registered. Reset values: si_en=0, sdo=0, cs_n=1, soc=0, busy=0, done=0, overrun=0; state=IDLE.
- Frame length F = CH_ADDR_W+DATA_W. Channel k's frame is {k[CH_ADDR_W-1:0], word_k}.
- States: IDLE, SHIFT, GAP, SOC.
- IDLE:
  - On tick, latch data_in and ch_en into holding registers; later input changes have no effect on the frame in progress.
  - Select the lowest enabled channel and go to SHIFT.
  - If ch_en==0, pulse done next cycle, stay in IDLE, and emit no soc.
- SHIFT:
  - F cycles with cs_n=0, si_en=1, busy=1; sdo carries frame bit F-1 down to 0, one bit per cycle.
  - Then go to GAP.
- GAP:
  - GAP_CYC cycles with cs_n=1, si_en=0, sdo=0.
  - Then go to SHIFT for the next higher enabled channel; disabled channels are skipped at zero cost.
  - If no enabled channel remains, go to SOC.
- SOC:
  - SOC_LEN cycles with soc=1, cs_n=1.
  - Then go to IDLE, with done=1 and busy=0 on the first IDLE cycle.
- Cycle timing, with tick in cycle 0:
  - First sdo bit appears in cycle 1.
  - busy is high from cycle 1 to cycle B, where B = E*(F+GAP_CYC)+SOC_LEN and E is the number of enabled channels.
  - done is high in cycle B+1.
- A tick in the done cycle is accepted, so back-to-back frames are legal.
- A tick while busy=1 is ignored: overrun pulses the next cycle and the frame in progress is not disturbed.
- A tick coincident with rst is ignored.
- rst mid-frame aborts immediately: next cycle shows reset values (cs_n=1, no soc, no done); the partial frame is discarded.
- The channel index counter and bit counter are sized clog2. The bit counter counts down and never wraps past 0 within SHIFT.

Test Plan:
1. Defaults, ch_en=2'b11, data_in={16'h0F0F,16'hA5C3}, tick in cycle 0 -> cycles 1-18: sdo=00_1010010111000011, cs_n=0; cycle 19: cs_n=1; cycles 20-37: sdo=01_0000111100001111; cycle 38: cs_n=1; cycle 39: soc=1; cycle 40: done=1, busy=0.
2. ch_en=2'b10, same data -> only channel 1 frame (address 01) in cycles 1-18; soc in cycle 20; done in cycle 21.
3. ch_en=2'b00, tick -> done=1 in cycle 1; cs_n, soc and si_en never assert.
4. Second tick in cycle 10 of scenario 1 -> overrun=1 in cycle 11; frame bits are unchanged. A tick in cycle 40 (done cycle) starts a new frame in cycle 41.
5. rst high in cycle 25 of scenario 1 -> cycle 26: cs_n=1, si_en=0, busy=0, soc is never pulsed. A new tick is accepted from cycle 26.
6. DATA_W=12, N_CH=4, CH_ADDR_W=2, GAP_CYC=3, SOC_LEN=2, all channels enabled, 12'hFFF on every channel -> four 14-bit frames with addresses 00 to 11; busy lasts 4*17+2=70 cycles; soc high 2 cycles; done in cycle 71.

Source files
------------

// File: rtl/dac_serial_tx.sv
// Serial DAC frame transmitter: on each tick, snapshots N_CH channel words and shifts
// each enabled channel out MSB-first as {address, data}, then pulses soc.
module dac_serial_tx #(
  parameter int DATA_W    = 16,
  parameter int N_CH      = 2,
  parameter int CH_ADDR_W = 2,
  parameter int GAP_CYC   = 1,
  parameter int SOC_LEN   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [N_CH-1:0]        ch_en,
  output logic                   si_en,
  output logic                   sdo,
  output logic                   cs_n,
  output logic                   soc,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int F        = CH_ADDR_W + DATA_W;
  localparam int BIT_W    = $clog2(F);
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WAIT_MAX = (GAP_CYC > SOC_LEN) ? GAP_CYC : SOC_LEN;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [BIT_W-1:0]  BIT_TOP = BIT_W'(F - 1);
  localparam logic [WAIT_W-1:0] GAP_TOP = WAIT_W'(GAP_CYC - 1);
  localparam logic [WAIT_W-1:0] SOC_TOP = WAIT_W'(SOC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    SOC   = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [BIT_W-1:0]       bit_cnt_r, bit_cnt_s;
  logic [WAIT_W-1:0]      wait_cnt_r, wait_cnt_s;
  logic [CH_W-1:0]        ch_r, ch_s;
  logic [N_CH*DATA_W-1:0] data_r, data_s;
  logic [N_CH-1:0]        en_r, en_s;
  logic [CH_W:0]          first_s, next_s;
  logic [DATA_W-1:0]      word_s;
  logic [F-1:0]           frame_s;
  logic                   si_en_s, sdo_s, cs_n_s, soc_s, busy_s, done_s, overrun_s;

  // Lowest enabled channel with index >= start; MSB of the result flags a hit.
  function automatic logic [CH_W:0] find_ch(input logic [N_CH-1:0] en, input int start);
    logic [CH_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      r = (en[i] && (i >= start)) ? {1'b1, CH_W'(i)} : r;
    end
    return r;
  endfunction

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    wait_cnt_s = wait_cnt_r;
    ch_s       = ch_r;
    data_s     = data_r;
    en_s       = en_r;
    done_s     = 1'b0;
    overrun_s  = tick && (state_r != IDLE);
    first_s    = find_ch(ch_en, 0);
    next_s     = find_ch(en_r, int'(ch_r) + 1);

    case (state_r)
      IDLE: begin
        if (tick) begin
          data_s = data_in;
          en_s   = ch_en;
          if (first_s[CH_W]) begin
            state_s   = SHIFT;
            ch_s      = first_s[CH_W-1:0];
            bit_cnt_s = BIT_TOP;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r == '0) begin
          state_s    = GAP;
          wait_cnt_s = GAP_TOP;
        end else begin
          bit_cnt_s = bit_cnt_r - BIT_W'(1);
        end
      end
      GAP: begin
        if (wait_cnt_r == '0) begin
          if (next_s[CH_W]) begin
            state_s   = SHIFT;
            ch_s      = next_s[CH_W-1:0];
            bit_cnt_s = BIT_TOP;
          end else begin
            state_s    = SOC;
            wait_cnt_s = SOC_TOP;
          end
        end else begin
          wait_cnt_s = wait_cnt_r - WAIT_W'(1);
        end
      end
      SOC: begin
        if (wait_cnt_r == '0) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r - WAIT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Frame word comes from the next holding value so the first bit is valid on entry to SHIFT.
    word_s  = data_s[ch_s*DATA_W +: DATA_W];
    frame_s = {CH_ADDR_W'(ch_s), word_s};
    si_en_s = (state_s == SHIFT);
    cs_n_s  = !si_en_s;
    soc_s   = (state_s == SOC);
    busy_s  = (state_s != IDLE);
    sdo_s   = si_en_s ? frame_s[bit_cnt_s] : 1'b0;
  end

  // State, holding registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= '0;
      wait_cnt_r <= '0;
      ch_r       <= '0;
      data_r     <= '0;
      en_r       <= '0;
      si_en      <= 1'b0;
      sdo        <= 1'b0;
      cs_n       <= 1'b1;
      soc        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      wait_cnt_r <= wait_cnt_s;
      ch_r       <= ch_s;
      data_r     <= data_s;
      en_r       <= en_s;
      si_en      <= si_en_s;
      sdo        <= sdo_s;
      cs_n       <= cs_n_s;
      soc        <= soc_s;
      busy       <= busy_s;
      done       <= done_s;
      overrun    <= overrun_s;
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: default build plus a 4-channel, wider-gap build.
module tb_dac_serial_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  ch_en = 2'b00;
  logic        si_en, sdo, cs_n, soc, busy, done, overrun;

  logic [47:0] data_in6 = {4{12'hFFF}};
  logic [3:0]  ch_en6 = 4'hF;
  logic        si_en6, sdo6, cs_n6, soc6, busy6, done6, overrun6;

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] v, v6;
  logic [6:0] tr  [0:127];
  logic [6:0] tr6 [0:127];

  // Output vector order: {si_en, sdo, cs_n, soc, busy, done, overrun}
  localparam logic [6:0] IDLE_V = 7'b0010000;
  localparam logic [6:0] GAP_V  = 7'b0010100;
  localparam logic [6:0] SOC_V  = 7'b0011100;
  localparam logic [6:0] DONE_V = 7'b0010010;
  localparam logic [17:0] FR0 = 18'b00_1010010111000011;
  localparam logic [17:0] FR1 = 18'b01_0000111100001111;

  assign v  = {si_en, sdo, cs_n, soc, busy, done, overrun};
  assign v6 = {si_en6, sdo6, cs_n6, soc6, busy6, done6, overrun6};

  always #5 clk = ~clk;

  dac_serial_tx dut (
    .clk(clk), .rst(rst), .tick(tick), .data_in(data_in), .ch_en(ch_en),
    .si_en(si_en), .sdo(sdo), .cs_n(cs_n), .soc(soc), .busy(busy),
    .done(done), .overrun(overrun)
  );

  dac_serial_tx #(.DATA_W(12), .N_CH(4), .CH_ADDR_W(2), .GAP_CYC(3), .SOC_LEN(2)) dut6 (
    .clk(clk), .rst(rst), .tick(tick), .data_in(data_in6), .ch_en(ch_en6),
    .si_en(si_en6), .sdo(sdo6), .cs_n(cs_n6), .soc(soc6), .busy(busy6),
    .done(done6), .overrun(overrun6)
  );

  // Expected vector for default build: nf frames of 18 bits, 1 gap cycle, 1 soc cycle; tick in cycle 0.
  function automatic logic [6:0] exp_two(input int c, input logic [17:0] f0,
                                         input logic [17:0] f1, input int nf);
    int p;
    logic [6:0] r;
    r = IDLE_V;
    if (c >= 1 && c <= nf * 19) begin
      p = (c - 1) % 19;
      if (p < 18) r = {1'b1, (((c - 1) / 19) == 0) ? f0[17-p] : f1[17-p], 5'b00100};
      else r = GAP_V;
    end else if (c == nf * 19 + 1) begin
      r = SOC_V;
    end else if (c == nf * 19 + 2) begin
      r = DONE_V;
    end
    return r;
  endfunction

  // Expected vector for the 4-channel build: 14-bit frames {j, 12'hFFF}, 3 gap cycles, 2 soc cycles.
  function automatic logic [6:0] exp6(input int c);
    int p, j;
    logic [13:0] f;
    logic [6:0] r;
    r = IDLE_V;
    if (c >= 1 && c <= 68) begin
      p = (c - 1) % 17;
      j = (c - 1) / 17;
      f = {j[1:0], 12'hFFF};
      if (p < 14) r = {1'b1, f[13-p], 5'b00100};
      else r = GAP_V;
    end else if (c == 69 || c == 70) begin
      r = SOC_V;
    end else if (c == 71) begin
      r = DONE_V;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start_tick();
    @(posedge clk); #1;
    tick = 1'b1;
  endtask

  // Record cycles 1..n; optional extra ticks (ta, tb2), reset (trs) and data flip (td) in given cycles.
  task automatic capture(input int n, input int ta, input int tb2, input int trs, input int td);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      tr[c]  = v;
      tr6[c] = v6;
      tick = (c == ta) || (c == tb2);
      rst  = (c == trs);
      if (c == td) data_in = ~data_in;
    end
    tick = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (v !== IDLE_V) begin
      tests_failed++;
      $display("FAIL reset_values: got %b expected %b", v, IDLE_V);
    end
    tests_run++;
    if (v6 !== IDLE_V) begin
      tests_failed++;
      $display("FAIL reset_values6: got %b expected %b", v6, IDLE_V);
    end
    ch_en = 2'b11;
    tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (v !== IDLE_V) begin
      tests_failed++;
      $display("FAIL tick_with_rst: got %b expected %b", v, IDLE_V);
    end
  endtask

  task automatic test_two_channels();
    do_reset();
    data_in = {16'h0F0F, 16'hA5C3};
    ch_en = 2'b11;
    start_tick();
    capture(44, 0, 0, 0, 5);
    for (int c = 1; c <= 44; c++) begin
      tests_run++;
      if (tr[c] !== exp_two(c, FR0, FR1, 2)) begin
        tests_failed++;
        $display("FAIL two_channels cycle %0d: got %b expected %b", c, tr[c], exp_two(c, FR0, FR1, 2));
      end
    end
  endtask

  task automatic test_single_high();
    do_reset();
    data_in = {16'h0F0F, 16'hA5C3};
    ch_en = 2'b10;
    start_tick();
    capture(24, 0, 0, 0, 0);
    for (int c = 1; c <= 24; c++) begin
      tests_run++;
      if (tr[c] !== exp_two(c, FR1, FR1, 1)) begin
        tests_failed++;
        $display("FAIL single_high cycle %0d: got %b expected %b", c, tr[c], exp_two(c, FR1, FR1, 1));
      end
    end
  endtask

  task automatic test_no_channels();
    logic [6:0] e;
    do_reset();
    ch_en = 2'b00;
    start_tick();
    capture(6, 0, 0, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      e = (c == 1) ? DONE_V : IDLE_V;
      tests_run++;
      if (tr[c] !== e) begin
        tests_failed++;
        $display("FAIL no_channels cycle %0d: got %b expected %b", c, tr[c], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    do_reset();
    data_in = {16'h0F0F, 16'hA5C3};
    ch_en = 2'b11;
    start_tick();
    capture(62, 10, 40, 0, 0);
    for (int c = 1; c <= 62; c++) begin
      if (c == 11) e = exp_two(c, FR0, FR1, 2) | 7'b0000001;
      else if (c <= 40) e = exp_two(c, FR0, FR1, 2);
      else e = exp_two(c - 40, FR0, FR1, 2);
      tests_run++;
      if (tr[c] !== e) begin
        tests_failed++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, tr[c], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    do_reset();
    data_in = {16'h0F0F, 16'hA5C3};
    ch_en = 2'b11;
    start_tick();
    capture(70, 26, 0, 25, 0);
    for (int c = 1; c <= 70; c++) begin
      if (c <= 25) e = exp_two(c, FR0, FR1, 2);
      else if (c == 26) e = IDLE_V;
      else e = exp_two(c - 26, FR0, FR1, 2);
      tests_run++;
      if (tr[c] !== e) begin
        tests_failed++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", c, tr[c], e);
      end
    end
  endtask

  task automatic test_four_channels();
    do_reset();
    start_tick();
    capture(74, 0, 0, 0, 0);
    for (int c = 1; c <= 74; c++) begin
      tests_run++;
      if (tr6[c] !== exp6(c)) begin
        tests_failed++;
        $display("FAIL four_channels cycle %0d: got %b expected %b", c, tr6[c], exp6(c));
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_channels();
    test_single_high();
    test_no_channels();
    test_back_to_back();
    test_reset_mid();
    test_four_channels();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
